text_word_counter: RTL and testbench
====================================

// Module: text_word_counter
// PURPOSE
// - Streaming consumer of the SD sector byte stream (sd_dout/sd_valid from sd_card), one byte per valid cycle.
// - Hunts for the start tag "DLAB_TAG", then counts whole-word "the" until the end tag "DLAB_END".
// - Exposes the count in binary and as two ASCII digits for the LCD row formatter.
// - Block sequencing (next rd_req/blk_addr) stays in the top FSM; this block spans any number of sectors.
// PARAMETERS
// - CNT_W      7   width of match_cnt
// - MAX_COUNT  99  saturation value of match_cnt; must be <= 99 and < 2**CNT_W
// PORTS
// - clk        in   1      system clock; all logic on its rising edge
// - reset_n    in   1      asynchronous, active-low reset
// - start      in   1      one-cycle pulse: clear all state, enter S_HUNT
// - in_valid   in   1      in_data valid this cycle (sd_valid)
// - in_data    in   8      stream byte (sd_dout)
// - busy       out  1      1 in S_HUNT or S_SCAN
// - tag_found  out  1      1 from start-tag match until next start/reset
// - done       out  1      level, 1 in S_DONE
// - match_cnt  out  CNT_W  whole-word "the" count, saturating
// - saturated  out  1      sticky: a match occurred while match_cnt == MAX_COUNT
// - cnt_ascii  out  16     {tens, ones} ASCII ('0'=8'h30) of match_cnt, registered
// BEHAVIOUR
// - Reset: S_IDLE; busy=0, tag_found=0, done=0, match_cnt=0, saturated=0, cnt_ascii="00", window and word state cleared.
// - States: S_IDLE -start-> S_HUNT -tag-> S_SCAN -end tag-> S_DONE -start-> S_HUNT.
// - start has priority in every state: clears everything except cnt_ascii (-> "00" next cycle), enters S_HUNT. A byte valid in the start cycle is discarded.
// - Window: 64-bit shift register, shifted left by in_data on every in_valid in S_HUNT/S_SCAN. Tag compare uses {win[55:0], in_data}, so a tag completes on its own last byte.
// - S_HUNT: compare "DLAB_TAG" -> S_SCAN, tag_found=1 next cycle; word tracker primed as if a delimiter was just seen.
// - S_SCAN: compare "DLAB_END" -> S_DONE, done=1 the cycle after the final 'D'. The final 'D' does not feed the word tracker.
// - Delimiters: 8'h20, 8'h0A, 8'h0D, 8'h09.
// - Word tracker (S_SCAN only), per valid byte:
//   - Delimiter: if the current word is exactly t,h,e (pos==3, not spoiled), count once. Then reset to pos=0, word start.
//   - Non-delimiter at pos 0..2 matching the expected letter: pos++.
//   - Any other non-delimiter: spoiled until the next delimiter.
// - "the" directly followed by the end tag (no delimiter) is not counted; "the" + delimiter + "DLAB_END" is counted.
// - Count update is registered: match_cnt changes the cycle after the closing delimiter.
// - At MAX_COUNT a further match holds the count and sets saturated.
// - cnt_ascii is registered from match_cnt (tens = cnt/10, ones = cnt%10): one cycle behind match_cnt.
// - In S_IDLE and S_DONE, in_valid is ignored; the window does not shift.
// - Bytes between sectors need no special handling: matching spans sd_valid gaps of any length.
// - Asynchronous reset mid-stream aborts immediately; no partial count is retained.
// CONFIGURATION
// - CASE_INSENSITIVE_EN defined: word letters match either case ('T'/'t', 'H'/'h', 'E'/'e').
//   - Tags stay case-exact uppercase in both builds.
// - Not defined: lowercase only; "The" spoils the word and is not counted.
// TESTING
// - Reset then start; stream "xxDLAB_TAG the cat DLAB_END" -> tag_found after 'G'; match_cnt=1; done=1 one cycle after last 'D'; cnt_ascii="01".
// - Stream "DLAB_TAG\nthe\rthe\tthem other bathe the DLAB_END" -> match_cnt=3 (them/other/bathe rejected).
// - Stream "DLAB_TAG The THE the DLAB_END" -> match_cnt=3 with CASE_INSENSITIVE_EN, 1 without.
// - 105 " the" words between tags, spread over 3 sectors with 20-cycle in_valid gaps:
//   match_cnt=99, saturated=1, cnt_ascii="99".
// - start pulsed mid-S_SCAN with count 5, same cycle as a valid byte:
//   next cycle S_HUNT, match_cnt=0, tag_found=0, byte discarded; one cycle later cnt_ascii="00".
// - reset_n low mid-S_SCAN, asynchronous to clk -> all outputs at reset values without a clock edge; "the DLAB_END" after release is not counted.

Source files
------------

// File: rtl/text_word_counter.sv
// Counts whole-word "the" in a byte stream between the DLAB_TAG and DLAB_END markers.
// Build option: define CASE_INSENSITIVE_EN to accept word letters in either case.
module text_word_counter #(
  parameter int CNT_W     = 7,
  parameter int MAX_COUNT = 99
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             busy_o,
  output logic             tag_found_o,
  output logic             done_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             saturated_o,
  output logic [15:0]      cnt_ascii_o
);

  // state  | meaning
  // S_IDLE | waiting for start, stream ignored
  // S_HUNT | shifting window, looking for DLAB_TAG
  // S_SCAN | tracking words, looking for DLAB_END
  // S_DONE | end tag seen, count frozen until start
  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_SCAN, S_DONE} state_t;

  localparam logic [63:0]      TAG_START  = "DLAB_TAG";
  localparam logic [63:0]      TAG_END    = "DLAB_END";
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] TEN        = CNT_W'(10);
  localparam logic [15:0]      ASCII_ZERO = 16'h3030;

  state_t           state_q, state_d;
  // Only the older 7 bytes are stored; the incoming byte completes the 64-bit window.
  logic [55:0]      win_q, win_d;
  logic [63:0]      win_next;
  logic [1:0]       pos_q, pos_d;
  logic             spoil_q, spoil_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             tag_q, tag_d;
  logic [15:0]      ascii_q, ascii_d;
  logic [CNT_W-1:0] tens, ones;

  function automatic logic is_delim(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h0A) || (b == 8'h0D) || (b == 8'h09);
  endfunction

  function automatic logic letter_ok(input logic [1:0] pos, input logic [7:0] b);
    logic [7:0] want;
    logic [7:0] got;
    case (pos)
      2'd0:    want = 8'h74;
      2'd1:    want = 8'h68;
      default: want = 8'h65;
    endcase
`ifdef CASE_INSENSITIVE_EN
    got = b | 8'h20;
`else
    got = b;
`endif
    return got == want;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      pos_q   <= '0;
      spoil_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      tag_q   <= 1'b0;
      ascii_q <= ASCII_ZERO;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pos_q   <= pos_d;
      spoil_q <= spoil_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      tag_q   <= tag_d;
      ascii_q <= ascii_d;
    end
  end

  always_comb begin
    win_next = {win_q, in_data_i};
    state_d  = state_q;
    win_d    = win_q;
    pos_d    = pos_q;
    spoil_d  = spoil_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    tag_d    = tag_q;
    if (start_i) begin
      state_d = S_HUNT;
      win_d   = '0;
      pos_d   = '0;
      spoil_d = 1'b0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      tag_d   = 1'b0;
    end else if (in_valid_i) begin
      case (state_q)
        S_HUNT: begin
          win_d = win_next[55:0];
          if (win_next == TAG_START) begin
            state_d = S_SCAN;
            tag_d   = 1'b1;
            pos_d   = '0;
            spoil_d = 1'b0;
          end
        end
        S_SCAN: begin
          win_d = win_next[55:0];
          if (win_next == TAG_END) begin
            state_d = S_DONE;
          end else if (is_delim(in_data_i)) begin
            if (pos_q == 2'd3 && !spoil_q) begin
              if (cnt_q == CNT_MAX) sat_d = 1'b1;
              else                  cnt_d = cnt_q + CNT_W'(1);
            end
            pos_d   = '0;
            spoil_d = 1'b0;
          end else if (!spoil_q && pos_q != 2'd3 && letter_ok(pos_q, in_data_i)) begin
            pos_d = pos_q + 2'd1;
          end else begin
            spoil_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tens    = cnt_q / TEN;
  assign ones    = cnt_q % TEN;
  assign ascii_d = {8'h30 + 8'(tens), 8'h30 + 8'(ones)};

  assign busy_o      = (state_q == S_HUNT) || (state_q == S_SCAN);
  assign done_o      = (state_q == S_DONE);
  assign tag_found_o = tag_q;
  assign match_cnt_o = cnt_q;
  assign saturated_o = sat_q;
  assign cnt_ascii_o = ascii_q;

endmodule

// File: tb/tb_text_word_counter.sv
// Self-checking bench for text_word_counter: directed streams plus random text
// checked against a token-level reference model.
`timescale 1ns/1ps
module tb_text_word_counter;
  localparam int CNT_W = 7;
  localparam int MAXC  = 99;
  localparam logic [63:0] P_TAG = "DLAB_TAG";
  localparam logic [63:0] P_END = "DLAB_END";

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             busy, tag_found, done, saturated;
  logic [CNT_W-1:0] match_cnt;
  logic [15:0]      cnt_ascii;

  int total = 0;
  int bad = 0;
  logic [7:0] stim[$];
  string pool[12] = '{"the", "The", "THE", "them", "bathe", "other",
                      "cat", "th", "he", "t", "tHe", "xthe"};
  logic [7:0] dls[4] = '{8'h20, 8'h0A, 8'h0D, 8'h09};

  always #5 clk = ~clk;

  text_word_counter #(.CNT_W(CNT_W), .MAX_COUNT(MAXC)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
    .in_valid_i(in_valid), .in_data_i(in_data),
    .busy_o(busy), .tag_found_o(tag_found), .done_o(done),
    .match_cnt_o(match_cnt), .saturated_o(saturated), .cnt_ascii_o(cnt_ascii)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int gap_max, input int sector_len, input int sector_gap);
    for (int i = 0; i < stim.size(); i++) begin
      if (sector_len > 0 && i > 0 && (i % sector_len) == 0) idle(sector_gap);
      send(stim[i]);
      if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
    end
  endtask

  function automatic bit at(input int i, input logic [63:0] p);
    if (i < 7) return 1'b0;
    for (int k = 0; k < 8; k++)
      if (stim[i-7+k] != p[63-8*k -: 8]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit is_dl(input logic [7:0] b);
    return b == 8'h20 || b == 8'h0A || b == 8'h0D || b == 8'h09;
  endfunction

  function automatic logic [7:0] lc(input logic [7:0] b);
`ifdef CASE_INSENSITIVE_EN
    return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
`else
    return b;
`endif
  endfunction

  // Reference: locate the tags, split the body into delimiter-terminated tokens,
  // count tokens spelling "the"; an unterminated trailing token never counts.
  function automatic void model(output bit tag, output bit fin, output int cnt);
    int t_end;
    int stop;
    int len;
    logic [7:0] w0, w1, w2;
    tag = 1'b0; fin = 1'b0; cnt = 0; t_end = -1;
    w0 = 8'h00; w1 = 8'h00; w2 = 8'h00; len = 0;
    for (int i = 0; i < stim.size(); i++)
      if (t_end < 0 && at(i, P_TAG)) t_end = i;
    if (t_end < 0) return;
    tag  = 1'b1;
    stop = stim.size();
    for (int i = t_end + 8; i < stim.size(); i++)
      if (!fin && at(i, P_END)) begin fin = 1'b1; stop = i - 7; end
    for (int i = t_end + 1; i < stop; i++) begin
      if (is_dl(stim[i])) begin
        if (len == 3 && lc(w0) == 8'h74 && lc(w1) == 8'h68 && lc(w2) == 8'h65) cnt++;
        len = 0;
      end else begin
        if (len == 0) w0 = stim[i];
        if (len == 1) w1 = stim[i];
        if (len == 2) w2 = stim[i];
        len++;
      end
    end
  endfunction

  task automatic check_model(input string name);
    bit tag, fin;
    int cnt, ec;
    model(tag, fin, cnt);
    ec = (cnt > MAXC) ? MAXC : cnt;
    chk({name, "_tag_found"}, 32'(tag_found), 32'(tag));
    chk({name, "_done"}, 32'(done), 32'(fin));
    chk({name, "_busy"}, 32'(busy), 32'(!fin));
    chk({name, "_match_cnt"}, 32'(match_cnt), 32'(ec));
    chk({name, "_saturated"}, 32'(saturated), 32'(cnt > MAXC));
    chk({name, "_cnt_ascii"}, 32'(cnt_ascii), 32'(((48 + ec / 10) << 8) | (48 + ec % 10)));
  endtask

  initial begin
    int nw;
    idle(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tag", 32'(tag_found), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_sat", 32'(saturated), 32'd0);
    chk("rst_ascii", 32'(cnt_ascii), 32'h3030);
    reset_n = 1'b1;
    idle(1);

    // Bytes in S_IDLE are ignored
    stim.delete(); push_str("DLAB_TAG the ");
    feed(0, 0, 0);
    chk("idle_tag", 32'(tag_found), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    stim.delete(); push_str("xxDLAB_TAG the cat DLAB_END");
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < stim.size(); i++) begin
      send(stim[i]);
      if (i == 8) chk("t1_tag_before_G", 32'(tag_found), 32'd0);
      if (i == 9) chk("t1_tag_after_G", 32'(tag_found), 32'd1);
      if (i == stim.size() - 2) chk("t1_done_before_D", 32'(done), 32'd0);
      if (i == stim.size() - 1) chk("t1_done_after_D", 32'(done), 32'd1);
    end
    chk("t1_cnt", 32'(match_cnt), 32'd1);
    idle(2);
    chk("t1_ascii", 32'(cnt_ascii), 32'h3031);
    check_model("t1");

    stim.delete(); push_str("DLAB_TAG\nthe\rthe\tthem other bathe the DLAB_END");
    pulse_start(); feed(2, 0, 0); idle(2);
    chk("t2_cnt", 32'(match_cnt), 32'd3);
    check_model("t2");

    stim.delete(); push_str("DLAB_TAG The THE the DLAB_END");
    pulse_start(); feed(1, 0, 0); idle(2);
`ifdef CASE_INSENSITIVE_EN
    chk("t3_cnt", 32'(match_cnt), 32'd3);
`else
    chk("t3_cnt", 32'(match_cnt), 32'd1);
`endif
    check_model("t3");

    stim.delete(); push_str("DLAB_TAG");
    repeat (105) push_str(" the");
    push_str(" DLAB_END");
    pulse_start(); feed(0, 150, 20); idle(2);
    chk("t4_cnt", 32'(match_cnt), 32'd99);
    chk("t4_sat", 32'(saturated), 32'd1);
    chk("t4_ascii", 32'(cnt_ascii), 32'h3939);
    check_model("t4");

    // start collides with a valid 'D'; a kept 'D' would let "LAB_TAG" match
    stim.delete(); push_str("DLAB_TAG the the the the the ");
    pulse_start(); feed(0, 0, 0); idle(1);
    chk("t5_cnt_pre", 32'(match_cnt), 32'd5);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h44;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_tag", 32'(tag_found), 32'd0);
    chk("t5_cnt", 32'(match_cnt), 32'd0);
    chk("t5_ascii_lag", 32'(cnt_ascii), 32'h3035);
    tick();
    chk("t5_ascii", 32'(cnt_ascii), 32'h3030);
    stim.delete(); push_str("LAB_TAG");
    feed(0, 0, 0); idle(1);
    chk("t5_discard", 32'(tag_found), 32'd0);

    stim.delete(); push_str("DLAB_TAG the the ");
    pulse_start(); feed(0, 0, 0); idle(1);
    chk("t6_cnt_pre", 32'(match_cnt), 32'd2);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tag", 32'(tag_found), 32'd0);
    chk("t6_cnt", 32'(match_cnt), 32'd0);
    chk("t6_ascii", 32'(cnt_ascii), 32'h3030);
    #1 reset_n = 1'b1;
    tick();
    stim.delete(); push_str("the DLAB_END");
    feed(0, 0, 0); idle(2);
    chk("t6_post_cnt", 32'(match_cnt), 32'd0);
    chk("t6_post_done", 32'(done), 32'd0);

    for (int it = 0; it < 24; it++) begin
      stim.delete();
      repeat ($urandom_range(0, 3)) begin
        push_str(pool[$urandom_range(0, 11)]);
        stim.push_back(dls[$urandom_range(0, 3)]);
      end
      push_str("DLAB_TAG");
      if ($urandom_range(0, 1) == 1) stim.push_back(dls[$urandom_range(0, 3)]);
      nw = int'($urandom_range(0, 30));
      for (int w = 0; w < nw; w++) begin
        push_str(pool[$urandom_range(0, 11)]);
        stim.push_back(dls[$urandom_range(0, 3)]);
        if ($urandom_range(0, 4) == 0) stim.push_back(dls[$urandom_range(0, 3)]);
      end
      if ($urandom_range(0, 3) == 0) push_str("the");
      if ($urandom_range(0, 4) != 0) push_str("DLAB_END");
      push_str(" the the ");
      pulse_start(); feed(3, 0, 0); idle(2);
      check_model($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
